red_pitaya_spi_slave: RTL and testbench

//  SPI responder (slave) implementing the same frame format the housekeeping spi_master issues:
//  16-bit header (bit15 = 1 read / 0 write, bits[14:0] address), then 8-bit data phase.

---
 rtl/red_pitaya_spi_slave.sv | 184 ++++++++++++++++++
 tb/tb_red_pitaya_spi_slave.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_spi_slave.sv
// SPI responder with a 2^AW x 8 register file, also reachable from a local port.
// Frame: 16-bit header (bit15 = read, low bits = address) then one 8-bit data phase.
// SCLK idles high: MOSI is sampled on rising edges, MISO changes on falling edges, MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for chip select to fall
// ST_HDR  | shifting in the 16 header bits
// ST_DAT  | data phase: shifting in write data or shifting out read data
// ST_DONE | frame complete, further SCLK edges ignored until CS rises
module red_pitaya_spi_slave #(
    parameter int          AW      = 5,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          spi_cs_i,
    input  logic          spi_clk_i,
    input  logic          spi_mosi_i,
    output logic          spi_miso_o,
    output logic          spi_miso_oe,
    input  logic          loc_wen_i,
    input  logic [AW-1:0] loc_addr_i,
    input  logic [7:0]    loc_wdata_i,
    output logic [7:0]    loc_rdata_o,
    output logic          wr_stb_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          frm_err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DAT, ST_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [1:0]    r_cs_s, r_sclk_s, r_mosi_s;
    logic          r_cs_d, r_sclk_d;
    logic [3:0]    r_bcnt;
    logic [14:0]   r_hdr;
    logic [6:0]    r_rx;
    logic [7:0]    r_tx;
    logic          r_rw, r_in_range, r_miso;
    logic [AW-1:0] r_addr;
    logic          r_wr_stb, r_frm_err;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_loc_rdata;
    logic [7:0]    r_mem [0:(2**AW)-1];

    logic          w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_mosi;
    logic          w_bit_last, w_frame_start, w_hdr_end, w_dat_end, w_abort, w_commit;
    logic [15:0]   w_hdr_nxt;
    logic [7:0]    w_rx_nxt;
    logic          w_hdr_in_range;

    assign w_mosi         = r_mosi_s[1];
    assign w_cs_fall      = r_cs_d & ~r_cs_s[1];
    assign w_cs_rise      = ~r_cs_d & r_cs_s[1];
    assign w_sclk_rise    = ~r_sclk_d & r_sclk_s[1];
    assign w_sclk_fall    = r_sclk_d & ~r_sclk_s[1];
    assign w_bit_last     = (r_bcnt == 4'd0);
    assign w_hdr_nxt      = {r_hdr, w_mosi};
    assign w_rx_nxt       = {r_rx, w_mosi};
    assign w_hdr_in_range = (w_hdr_nxt[14:AW] == '0);
    assign w_commit       = w_dat_end & ~r_rw & r_in_range;

    assign wr_stb_o    = r_wr_stb;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign frm_err_o   = r_frm_err;
    assign loc_rdata_o = r_loc_rdata;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode and MISO drive; CS rising takes priority over SCLK edges
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_hdr_end     = 1'b0;
        w_dat_end     = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            ST_IDLE: if (w_cs_fall) begin
                w_state_nxt   = ST_HDR;
                w_frame_start = 1'b1;
            end
            ST_HDR: if (w_cs_rise) begin
                w_state_nxt = ST_IDLE;
                w_abort     = 1'b1;
            end else if (w_sclk_rise && w_bit_last) begin
                w_state_nxt = ST_DAT;
                w_hdr_end   = 1'b1;
            end
            ST_DAT: if (w_cs_rise) begin
                w_state_nxt = ST_IDLE;
                w_abort     = 1'b1;
            end else if (w_sclk_rise && w_bit_last) begin
                w_state_nxt = ST_DONE;
                w_dat_end   = 1'b1;
            end
            ST_DONE: if (w_cs_rise) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        spi_miso_oe = (r_state == ST_DAT) && r_rw;
        spi_miso_o  = spi_miso_oe & r_miso;
    end

    // Synchronisers, bit counting, shift registers and status pulses
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cs_s     <= '0;
            r_sclk_s   <= '0;
            r_mosi_s   <= '0;
            r_cs_d     <= 1'b0;
            r_sclk_d   <= 1'b0;
            r_bcnt     <= '0;
            r_hdr      <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_rw       <= 1'b0;
            r_in_range <= 1'b0;
            r_addr     <= '0;
            r_miso     <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_frm_err  <= 1'b0;
        end else begin
            r_cs_s   <= {r_cs_s[0], spi_cs_i};
            r_sclk_s <= {r_sclk_s[0], spi_clk_i};
            r_mosi_s <= {r_mosi_s[0], spi_mosi_i};
            r_cs_d   <= r_cs_s[1];
            r_sclk_d <= r_sclk_s[1];
            r_wr_stb  <= w_commit;
            r_frm_err <= w_abort;
            if (w_frame_start) r_bcnt <= 4'd15;
            if (r_state == ST_HDR && w_sclk_rise && !w_cs_rise) begin
                r_hdr  <= w_hdr_nxt[14:0];
                r_bcnt <= r_bcnt - 4'd1;
            end
            // Read data is snapshotted here so later local writes cannot disturb bits in flight
            if (w_hdr_end) begin
                r_rw       <= w_hdr_nxt[15];
                r_addr     <= w_hdr_nxt[AW-1:0];
                r_in_range <= w_hdr_in_range;
                r_tx       <= w_hdr_in_range ? r_mem[w_hdr_nxt[AW-1:0]] : 8'h00;
                r_bcnt     <= 4'd7;
                r_miso     <= 1'b0;
            end
            if (r_state == ST_DAT && !w_cs_rise) begin
                if (w_sclk_rise) begin
                    r_rx   <= w_rx_nxt[6:0];
                    r_bcnt <= r_bcnt - 4'd1;
                end
                if (w_sclk_fall && r_rw) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end
            if (w_commit) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_rx_nxt;
            end
        end
    end

    // Register file; the SPI commit is written last so it wins an address collision
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2**AW; i++) r_mem[i] <= RST_VAL;
            r_loc_rdata <= '0;
        end else begin
            if (loc_wen_i) r_mem[loc_addr_i] <= loc_wdata_i;
            if (w_commit)  r_mem[r_addr] <= w_rx_nxt;
            r_loc_rdata <= r_mem[loc_addr_i];
        end
    end

endmodule

// File: tb/tb_red_pitaya_spi_slave.sv
// Directed bench for red_pitaya_spi_slave: SPI signals are driven on clk falling edges,
// five clk cycles per SCLK half period.
module tb_red_pitaya_spi_slave;

    localparam int AW = 5;
    localparam int HP = 5;

    logic          clk = 1'b0;
    logic          rstn, cs, sclk, mosi;
    logic          miso, oe;
    logic          wen;
    logic [AW-1:0] addr;
    logic [7:0]    wdata, rdata;
    logic          wr_stb, frm_err;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    int n_chk = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_data;

    logic [7:0] rx, rd;
    logic       oe_hdr, oe_dat;

    red_pitaya_spi_slave #(.AW(AW), .RST_VAL(8'h00)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .spi_cs_i    (cs),
        .spi_clk_i   (sclk),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .spi_miso_oe (oe),
        .loc_wen_i   (wen),
        .loc_addr_i  (addr),
        .loc_wdata_i (wdata),
        .loc_rdata_o (rdata),
        .wr_stb_o    (wr_stb),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .frm_err_o   (frm_err)
    );

    always #5 clk = ~clk;

    // Count strobe/error cycles and remember the last committed write
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (frm_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk); wen = 1'b1; addr = a; wdata = d;
        @(negedge clk); wen = 1'b0;
    endtask

    task automatic loc_read(input logic [AW-1:0] a, output logic [7:0] d);
        @(negedge clk); addr = a;
        @(negedge clk); d = rdata;
    endtask

    // nbits: bits clocked before CS rises; loc_hit: local write to addr 2 in the commit cycle;
    // rst_at: bit index at which rstn is pulsed low (-1 = never)
    task automatic spi_frame(input logic [15:0] hdr, input logic [7:0] dat, input int nbits,
                             input bit loc_hit, input int rst_at,
                             output logic [7:0] r, output logic o_hdr, output logic o_dat);
        r = 8'h00; o_hdr = 1'b0; o_dat = 1'b1;
        @(negedge clk); cs = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rstn = 1'b0;
                repeat (2) @(negedge clk);
                check("rst_mid_outs", {miso, oe, wr_stb, frm_err, wr_addr, wr_data}, 0);
                rstn = 1'b1;
            end
            sclk = 1'b0;
            if (i < 16) mosi = hdr[15-i];
            else        mosi = dat[23-i];
            repeat (HP) @(negedge clk);
            if (i < 16) o_hdr = o_hdr | oe;
            else begin
                o_dat = o_dat & oe;
                r[23-i] = miso;
            end
            sclk = 1'b1;
            if (loc_hit && i == 23) begin
                repeat (2) @(negedge clk);
                wen = 1'b1; addr = 5'd2; wdata = 8'hAA;
                @(negedge clk); wen = 1'b0;
                repeat (HP - 3) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
        end
        cs = 1'b1; mosi = 1'b0;
        repeat (4*HP) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
        wen = 1'b0; addr = '0; wdata = '0;
        repeat (4) @(negedge clk);
        check("reset_outs", {miso, oe, wr_stb, frm_err, wr_addr, wr_data, rdata}, 0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_no_err", err_cnt, 0);

        // 1: SPI write, then local readback
        stb_cnt = 0; err_cnt = 0;
        spi_frame(16'h0005, 8'hA5, 24, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("wr_stb_cycles", stb_cnt, 1);
        check("wr_addr", last_addr, 5);
        check("wr_data", last_data, 8'hA5);
        check("wr_no_err", err_cnt, 0);
        loc_read(5'd5, rd);
        check("loc_rd5", rd, 8'hA5);

        // 2: local write, SPI read
        loc_write(5'd3, 8'h3C);
        stb_cnt = 0;
        spi_frame(16'h8003, 8'h00, 24, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("rd_data", rx, 8'h3C);
        check("rd_oe_hdr", oe_hdr, 0);
        check("rd_oe_dat", oe_dat, 1);
        check("rd_oe_after", oe, 0);
        check("rd_no_stb", stb_cnt, 0);

        // 3: aborted write
        stb_cnt = 0; err_cnt = 0;
        spi_frame(16'h0007, 8'hFF, 10, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("abort_err", err_cnt, 1);
        check("abort_no_stb", stb_cnt, 0);
        loc_read(5'd7, rd);
        check("abort_reg7", rd, 8'h00);

        // 4: out-of-range write and read
        loc_write(5'd0, 8'h5A);
        stb_cnt = 0; err_cnt = 0;
        spi_frame(16'h0040, 8'h11, 24, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("oor_no_stb", stb_cnt, 0);
        check("oor_no_err", err_cnt, 0);
        loc_read(5'd0, rd);
        check("oor_reg0", rd, 8'h5A);
        spi_frame(16'h8040, 8'h00, 24, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("oor_rd", rx, 8'h00);
        spi_frame(16'h8000, 8'h00, 24, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("rd_reg0", rx, 8'h5A);

        // 5: SPI commit collides with local write
        stb_cnt = 0;
        spi_frame(16'h0002, 8'h55, 24, 1'b1, -1, rx, oe_hdr, oe_dat);
        check("coll_stb", stb_cnt, 1);
        loc_read(5'd2, rd);
        check("coll_reg2", rd, 8'h55);

        // 6: reset during the data phase, then a clean frame
        loc_write(5'd1, 8'h33);
        stb_cnt = 0; err_cnt = 0;
        spi_frame(16'h0001, 8'h77, 24, 1'b0, 20, rx, oe_hdr, oe_dat);
        check("rst_no_stb", stb_cnt, 0);
        check("rst_no_err", err_cnt, 0);
        loc_read(5'd1, rd);
        check("rst_reg1", rd, 8'h00);
        loc_read(5'd5, rd);
        check("rst_reg5", rd, 8'h00);
        spi_frame(16'h0001, 8'h77, 24, 1'b0, -1, rx, oe_hdr, oe_dat);
        check("post_rst_stb", stb_cnt, 1);
        loc_read(5'd1, rd);
        check("post_rst_reg1", rd, 8'h77);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
